// File: rtl/sdram_capture_writer.sv
`default_nettype none
// ============================================================================
// Module   : sdram_capture_writer
// Purpose  : Packs an 8-bit sample stream into 16-bit words, buffers them in a
//            small FIFO and writes them to SDRAM through an Avalon-MM master.
//            Address and write count start over on every capture.
// Ports    : M100CLK           - clock, rising edge
//            lock              - asynchronous active-low reset
//            start / abort     - one-cycle capture control pulses
//            in_valid/in_data/in_ready - byte input handshake
//            avm_*             - Avalon-MM write master
//            busy/done/overflow/words_written - capture status
// Revision : 1.0 - initial release
// ============================================================================
module sdram_capture_writer #(
    parameter logic [24:0] BASE_ADDR = 25'h0000000,
    parameter int unsigned LEN_WORDS = 25'd262144,
    parameter int unsigned FIFO_LOG2 = 4
) (
    input  logic        M100CLK,
    input  logic        lock,
    input  logic        start,
    input  logic        abort,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        avm_chipselect,
    output logic [24:0] avm_address,
    output logic [1:0]  avm_byteenable,
    output logic [15:0] avm_writedata,
    output logic        avm_write,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [24:0] words_written
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    localparam int unsigned            c_DEPTH   = 1 << FIFO_LOG2;
    localparam logic [25:0]            c_LEN     = 26'(LEN_WORDS);
    localparam logic [FIFO_LOG2-1:0]   c_PTR_ONE = FIFO_LOG2'(1);
    localparam logic [FIFO_LOG2:0]     c_CNT_ONE = (FIFO_LOG2+1)'(1);

    logic [1:0]            r_state;
    logic                  r_abort;       // abort wind-down in progress
    logic [15:0]           r_mem [0:c_DEPTH-1];
    logic [FIFO_LOG2-1:0]  r_rd_ptr;
    logic [FIFO_LOG2-1:0]  r_wr_ptr;
    logic [FIFO_LOG2:0]    r_count;
    logic [7:0]            r_lo;          // first byte of the pair being packed
    logic                  r_half;        // r_lo holds a valid byte
    logic                  r_pend;        // packed word waiting to enter the FIFO
    logic [15:0]           r_pend_word;
    logic [25:0]           r_formed;      // words formed this capture
    logic [24:0]           r_addr;
    logic [24:0]           r_words;
    logic                  r_ovf;

    logic                  w_active;
    logic [FIFO_LOG2+1:0]  w_occ;
    logic                  w_room;
    logic                  w_need;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_inflight;
    logic                  w_abort_go;

    assign w_active   = (r_state == c_CAPTURE) || (r_state == c_DRAIN);
    // The pending packed word already owns a FIFO slot, so count it as occupied;
    // this keeps a push from ever landing on a full FIFO.
    assign w_occ      = {1'b0, r_count} + {{(FIFO_LOG2+1){1'b0}}, r_pend};
    assign w_room     = (w_occ[FIFO_LOG2+1:FIFO_LOG2] == 2'b00);
    assign w_need     = (r_formed < c_LEN);
    assign in_ready   = (r_state == c_CAPTURE) && !r_abort && w_room && w_need;
    assign w_accept   = in_valid && in_ready;
    assign avm_write  = w_active && (r_count != '0);
    assign w_pop      = avm_write && !avm_waitrequest;
    assign w_inflight = avm_write && avm_waitrequest;
    assign w_abort_go = abort && w_active && !r_abort;
    assign w_push     = r_pend && !w_abort_go;

    assign avm_chipselect = avm_write;
    assign avm_byteenable = 2'b11;
    assign avm_address    = r_addr;
    // Masked so the bus shows zero whenever no write is presented.
    assign avm_writedata  = avm_write ? r_mem[r_rd_ptr] : 16'h0000;
    assign busy           = w_active || r_abort;
    assign done           = (r_state == c_DONE);
    assign overflow       = r_ovf;
    assign words_written  = r_words;

    always_ff @(posedge M100CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_pend_word;
        end
    end

    always_ff @(posedge M100CLK or negedge lock) begin
        if (!lock) begin
            r_state     <= c_IDLE;
            r_abort     <= 1'b0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_lo        <= 8'h00;
            r_half      <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_word <= 16'h0000;
            r_formed    <= 26'd0;
            r_addr      <= BASE_ADDR;
            r_words     <= 25'd0;
            r_ovf       <= 1'b0;
        end else begin
            r_pend <= 1'b0;

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_addr   <= r_addr + 25'd1;
                r_words  <= r_words + 25'd1;
            end

            if (w_abort_go) begin
                // Keep only the word stalled on the bus (if any); everything
                // behind it and the half-packed byte are thrown away.
                r_abort  <= 1'b1;
                r_half   <= 1'b0;
                r_wr_ptr <= (w_pop || w_inflight) ? r_rd_ptr + c_PTR_ONE : r_rd_ptr;
                r_count  <= w_inflight ? c_CNT_ONE : '0;
            end else begin
                if (w_accept) begin
                    if (r_half) begin
                        r_pend_word <= {in_data, r_lo};
                        r_pend      <= 1'b1;
                        r_half      <= 1'b0;
                        r_formed    <= r_formed + 26'd1;
                    end else begin
                        r_lo   <= in_data;
                        r_half <= 1'b1;
                    end
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_ONE;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CNT_ONE;
                end
            end

            if ((r_state == c_CAPTURE) && !r_abort && in_valid && !in_ready && w_need) begin
                r_ovf <= 1'b1;
            end

            case (r_state)
                c_IDLE, c_DONE: begin
                    if (start) begin
                        r_state  <= c_CAPTURE;
                        r_addr   <= BASE_ADDR;
                        r_words  <= 25'd0;
                        r_ovf    <= 1'b0;
                        r_formed <= 26'd0;
                        r_half   <= 1'b0;
                        r_pend   <= 1'b0;
                    end
                end
                c_CAPTURE: begin
                    if (r_abort) begin
                        if (r_count == '0) begin
                            r_state <= c_IDLE;
                            r_abort <= 1'b0;
                        end
                    end else if (!w_abort_go && (r_formed == c_LEN) && !r_pend) begin
                        r_state <= c_DRAIN;
                    end
                end
                c_DRAIN: begin
                    if (r_abort) begin
                        if (r_count == '0) begin
                            r_state <= c_IDLE;
                            r_abort <= 1'b0;
                        end
                    end else if (!w_abort_go && (r_count == '0) && !r_pend) begin
                        r_state <= c_DONE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_capture_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_capture_writer
// Purpose  : Scoreboard bench for sdram_capture_writer. Three instances share
//            the byte/bus stimulus: dut 0 (LEN 4, base 0), dut 1 (LEN 4, base
//            1FFFFFE, address wrap) and dut 2 (LEN 64, own start, overflow).
//            Expected writes are queued when bytes are issued; a per-instance
//            monitor pops and compares on every completed transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_capture_writer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        lock, start_ab, start_ov, abort, in_valid, waitreq;
    logic [7:0]  in_data;

    logic        rdy [3];
    logic        cs  [3];
    logic [24:0] addr[3];
    logic [1:0]  be  [3];
    logic [15:0] wd  [3];
    logic        wr  [3];
    logic        bsy [3];
    logic        dn  [3];
    logic        ov  [3];
    logic [24:0] ww  [3];

    logic [40:0] exp_q [3][$];
    int tests = 0;
    int fails = 0;

    sdram_capture_writer #(.BASE_ADDR(25'h0000000), .LEN_WORDS(4), .FIFO_LOG2(4)) u_d0 (
        .M100CLK(clk), .lock(lock), .start(start_ab), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
        .avm_chipselect(cs[0]), .avm_address(addr[0]), .avm_byteenable(be[0]),
        .avm_writedata(wd[0]), .avm_write(wr[0]), .avm_waitrequest(waitreq),
        .busy(bsy[0]), .done(dn[0]), .overflow(ov[0]), .words_written(ww[0]));

    sdram_capture_writer #(.BASE_ADDR(25'h1FFFFFE), .LEN_WORDS(4), .FIFO_LOG2(4)) u_d1 (
        .M100CLK(clk), .lock(lock), .start(start_ab), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
        .avm_chipselect(cs[1]), .avm_address(addr[1]), .avm_byteenable(be[1]),
        .avm_writedata(wd[1]), .avm_write(wr[1]), .avm_waitrequest(waitreq),
        .busy(bsy[1]), .done(dn[1]), .overflow(ov[1]), .words_written(ww[1]));

    sdram_capture_writer #(.BASE_ADDR(25'h0000000), .LEN_WORDS(64), .FIFO_LOG2(4)) u_d2 (
        .M100CLK(clk), .lock(lock), .start(start_ov), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[2]),
        .avm_chipselect(cs[2]), .avm_address(addr[2]), .avm_byteenable(be[2]),
        .avm_writedata(wd[2]), .avm_write(wr[2]), .avm_waitrequest(waitreq),
        .busy(bsy[2]), .done(dn[2]), .overflow(ov[2]), .words_written(ww[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp_v);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input int d, input logic [24:0] a, input logic [15:0] v);
        exp_q[d].push_back({a, v});
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        check("in_ready_before_byte", {31'd0, rdy[0]}, 32'd1);
        tick();
    endtask

    task automatic wait_done(input int d, input int lim);
        int n = 0;
        while (!dn[d] && n < lim) begin
            tick();
            n++;
        end
        if (!dn[d]) timeout($sformatf("dut%0d_done", d));
    endtask

    function automatic logic [7:0] bval(input int k);
        return 8'((k * 37 + 5) & 255);
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_mon
        logic [40:0] e;
        always @(negedge clk) begin
            if (lock && wr[gi] && !waitreq) begin
                if (exp_q[gi].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dut%0d_unexpected_write: addr %h data %h, required no write",
                             gi, addr[gi], wd[gi]);
                end else begin
                    e = exp_q[gi].pop_front();
                    check($sformatf("dut%0d_addr", gi), {7'd0, addr[gi]}, {7'd0, e[40:16]});
                    check($sformatf("dut%0d_data", gi), {16'd0, wd[gi]}, {16'd0, e[15:0]});
                    check($sformatf("dut%0d_cs", gi), {31'd0, cs[gi]}, 32'd1);
                    check($sformatf("dut%0d_be", gi), {30'd0, be[gi]}, 32'd3);
                end
            end
        end
    end

    initial begin
        int k;
        int n;
        logic acc;
        logic [24:0] hold_a;
        logic [15:0] hold_d;

        lock = 1'b1; start_ab = 1'b0; start_ov = 1'b0; abort = 1'b0;
        in_valid = 1'b0; in_data = 8'h00; waitreq = 1'b0;
        #3 lock = 1'b0;
        #10;
        // ---------------- reset values ----------------
        check("rst_in_ready", {31'd0, rdy[0]}, 32'd0);
        check("rst_write", {31'd0, wr[0]}, 32'd0);
        check("rst_cs", {31'd0, cs[0]}, 32'd0);
        check("rst_addr", {7'd0, addr[0]}, 32'd0);
        check("rst_addr_wrapdut", {7'd0, addr[1]}, 32'h1FFFFFE);
        check("rst_wdata", {16'd0, wd[0]}, 32'd0);
        check("rst_be", {30'd0, be[0]}, 32'd3);
        check("rst_busy", {31'd0, bsy[0]}, 32'd0);
        check("rst_done", {31'd0, dn[0]}, 32'd0);
        check("rst_ovf", {31'd0, ov[0]}, 32'd0);
        check("rst_words", {7'd0, ww[0]}, 32'd0);
        #4 lock = 1'b1;
        repeat (2) tick();

        // ---------------- basic + address wrap ----------------
        start_ab = 1'b1; tick(); start_ab = 1'b0;
        for (int j = 0; j < 4; j++) begin
            expect_wr(0, 25'(j), {8'(8'h11 * (2*j+2)), 8'(8'h11 * (2*j+1))});
            expect_wr(1, 25'h1FFFFFE + 25'(j), {8'(8'h11 * (2*j+2)), 8'(8'h11 * (2*j+1))});
        end
        for (int i = 0; i < 8; i++) send(8'(8'h11 * (i+1)));
        in_valid = 1'b0;
        wait_done(0, 50);
        check("basic_done", {31'd0, dn[0]}, 32'd1);
        check("basic_words", {7'd0, ww[0]}, 32'd4);
        check("basic_ovf", {31'd0, ov[0]}, 32'd0);
        check("basic_busy", {31'd0, bsy[0]}, 32'd0);
        check("wrap_done", {31'd0, dn[1]}, 32'd1);
        check("wrap_words", {7'd0, ww[1]}, 32'd4);
        check("basic_queue_left", exp_q[0].size(), 32'd0);
        check("wrap_queue_left", exp_q[1].size(), 32'd0);

        // ---------------- stall on the second word ----------------
        start_ab = 1'b1; tick(); start_ab = 1'b0;
        for (int j = 0; j < 4; j++) begin
            expect_wr(0, 25'(j), {8'(2*j+2), 8'(2*j+1)});
            expect_wr(1, 25'h1FFFFFE + 25'(j), {8'(2*j+2), 8'(2*j+1)});
        end
        fork
            begin
                for (int i = 0; i < 8; i++) send(8'(i+1));
                in_valid = 1'b0;
            end
            begin
                n = 0;
                while (!(wr[0] && addr[0] == 25'd1) && n < 100) begin
                    tick();
                    n++;
                end
                if (n >= 100) begin
                    timeout("stall_find_word2");
                end else begin
                    hold_a = addr[0];
                    hold_d = wd[0];
                    waitreq = 1'b1;
                    repeat (5) begin
                        tick();
                        check("stall_addr_stable", {7'd0, addr[0]}, {7'd0, hold_a});
                        check("stall_data_stable", {16'd0, wd[0]}, {16'd0, hold_d});
                        check("stall_write_held", {31'd0, wr[0]}, 32'd1);
                    end
                    waitreq = 1'b0;
                end
            end
        join
        wait_done(0, 100);
        check("stall_words", {7'd0, ww[0]}, 32'd4);
        check("stall_queue_left", exp_q[0].size(), 32'd0);

        // ---------------- abort with a stalled word in flight ----------------
        waitreq = 1'b1;
        start_ab = 1'b1; tick(); start_ab = 1'b0;
        expect_wr(0, 25'd0, 16'hA2A1);
        expect_wr(1, 25'h1FFFFFE, 16'hA2A1);
        for (int i = 0; i < 5; i++) send(8'(8'hA1 + i));
        in_valid = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        check("abort_in_ready", {31'd0, rdy[0]}, 32'd0);
        check("abort_busy", {31'd0, bsy[0]}, 32'd1);
        check("abort_write_held", {31'd0, wr[0]}, 32'd1);
        repeat (2) tick();
        waitreq = 1'b0;
        n = 0;
        while (bsy[0] && n < 20) begin
            tick();
            n++;
        end
        if (bsy[0]) timeout("abort_wind_down");
        repeat (5) tick();
        check("abort_done", {31'd0, dn[0]}, 32'd0);
        check("abort_words", {7'd0, ww[0]}, 32'd1);
        check("abort_idle_write", {31'd0, wr[0]}, 32'd0);
        check("abort_queue_left", exp_q[0].size(), 32'd0);

        // ---------------- overflow under a long stall ----------------
        waitreq = 1'b1;
        start_ov = 1'b1; tick(); start_ov = 1'b0;
        in_valid = 1'b1;
        k = 0;
        for (int it = 0; it < 40; it++) begin
            in_data = bval(k);
            acc = rdy[2];
            tick();
            if (acc) begin
                if (k % 2 == 1) expect_wr(2, 25'(k/2), {bval(k), bval(k-1)});
                k++;
            end
        end
        check("ovf_bytes_accepted", k, 32'd32);
        check("ovf_in_ready_low", {31'd0, rdy[2]}, 32'd0);
        check("ovf_flag", {31'd0, ov[2]}, 32'd1);
        waitreq = 1'b0;
        n = 0;
        while (k < 128 && n < 1000) begin
            in_data = bval(k);
            acc = rdy[2];
            tick();
            if (acc) begin
                if (k % 2 == 1) expect_wr(2, 25'(k/2), {bval(k), bval(k-1)});
                k++;
            end
            n++;
        end
        if (k < 128) timeout("ovf_feed");
        in_valid = 1'b0;
        wait_done(2, 100);
        check("ovf_words", {7'd0, ww[2]}, 32'd64);
        check("ovf_sticky", {31'd0, ov[2]}, 32'd1);
        check("ovf_queue_left", exp_q[2].size(), 32'd0);

        // ---------------- asynchronous reset mid-transfer ----------------
        waitreq = 1'b1;
        start_ab = 1'b1; tick(); start_ab = 1'b0;
        send(8'h5C);
        send(8'hC5);
        in_valid = 1'b0;
        n = 0;
        while (!wr[0] && n < 10) begin
            tick();
            n++;
        end
        if (!wr[0]) timeout("rst_mid_write_start");
        lock = 1'b0;
        #2;
        check("arst_write", {31'd0, wr[0]}, 32'd0);
        check("arst_cs", {31'd0, cs[0]}, 32'd0);
        check("arst_addr", {7'd0, addr[0]}, 32'd0);
        check("arst_wdata", {16'd0, wd[0]}, 32'd0);
        check("arst_be", {30'd0, be[0]}, 32'd3);
        check("arst_busy", {31'd0, bsy[0]}, 32'd0);
        check("arst_in_ready", {31'd0, rdy[0]}, 32'd0);
        check("arst_words", {7'd0, ww[0]}, 32'd0);
        check("arst_done_d2", {31'd0, dn[2]}, 32'd0);
        check("arst_ovf_d2", {31'd0, ov[2]}, 32'd0);
        check("arst_words_d2", {7'd0, ww[2]}, 32'd0);
        #10 lock = 1'b1;
        waitreq = 1'b0;
        repeat (5) tick();
        check("post_rst_busy", {31'd0, bsy[0]}, 32'd0);
        check("post_rst_write", {31'd0, wr[0]}, 32'd0);
        check("post_rst_done", {31'd0, dn[0]}, 32'd0);
        check("final_queue0", exp_q[0].size(), 32'd0);
        check("final_queue1", exp_q[1].size(), 32'd0);
        check("final_queue2", exp_q[2].size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_capture_writer.md
SDRAM_CAPTURE_WRITER -- requirements
Module: sdram_capture_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 25'h0000000: first SDRAM word address of a capture.
REQ-002 SHALL have parameter LEN_WORDS, default 25'd262144: number of 16-bit words written per capture, legal range 1..2^25.
REQ-003 SHALL have parameter FIFO_LOG2, default 4: the internal word FIFO holds 2^FIFO_LOG2 words (16).
REQ-004 Ports (name, direction, width, meaning) SHALL be:
- M100CLK  in  1  the single clock, rising edge.
- lock  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a capture.
- abort  in  1  one-cycle pulse that ends a capture early.
- in_valid  in  1  a sample byte is present.
- in_data  in  8  sample byte.
- in_ready  out  1  the byte is accepted on a cycle where in_valid and in_ready are both high.
- avm_chipselect  out  1  Avalon-MM chip select, active-high.
- avm_address  out  25  Avalon-MM word address.
- avm_byteenable  out  2  Avalon-MM byte enables.
- avm_writedata  out  16  Avalon-MM write data.
- avm_write  out  1  Avalon-MM write request, active-high.
- avm_waitrequest  in  1  Avalon-MM slave stall.
- busy  out  1  capture in progress.
- done  out  1  capture complete.
- overflow  out  1  sticky: a byte was dropped.
- words_written  out  25  completed write transfers in the current capture.

Function
REQ-005 SHALL implement FSM states IDLE, CAPTURE, DRAIN, DONE.
REQ-006 Transitions SHALL be:
- IDLE or DONE, on start: go to CAPTURE; clear words_written, overflow and the packer; set the address to BASE_ADDR.
- CAPTURE: go to DRAIN once LEN_WORDS words have been pushed into the FIFO.
- DRAIN: go to DONE once the FIFO is empty and no write is in flight.
- start in CAPTURE or DRAIN SHALL be ignored.
REQ-007 The packer SHALL place the first accepted byte of each pair in bits [7:0] and the second in [15:8], then push the word into the FIFO on the cycle after the second byte is accepted.
REQ-008 in_ready SHALL equal (state==CAPTURE) AND FIFO not full AND words-pushed < LEN_WORDS.
REQ-009 overflow SHALL set on any cycle with state==CAPTURE, in_valid=1 and in_ready=0 while words-pushed < LEN_WORDS; it SHALL stay set until the next start or reset.
REQ-010 A write transfer SHALL complete on a cycle with avm_write=1 and avm_waitrequest=0; that cycle pops the FIFO.
REQ-011 While avm_write=1 and avm_waitrequest=1, avm_address, avm_writedata and avm_byteenable SHALL be held stable, and avm_write SHALL not drop.
REQ-012 avm_write SHALL assert whenever the FIFO is non-empty in CAPTURE or DRAIN. The first word's write SHALL assert no more than 2 cycles after its second byte is accepted.
REQ-013 Back-to-back transfers SHALL sustain one word per cycle while avm_waitrequest=0.
REQ-014 avm_byteenable SHALL be 2'b11 and avm_chipselect SHALL equal avm_write.
REQ-015 avm_address SHALL increment by 1 per completed transfer, modulo 2^25; 25'h1FFFFFF SHALL wrap to 0.
REQ-016 words_written SHALL increment by 1 per completed transfer.
REQ-017 A FIFO push and a pop on the same cycle SHALL leave the occupancy unchanged. No push SHALL occur when the FIFO is full.
REQ-018 abort in CAPTURE or DRAIN SHALL:
- drop in_ready the next cycle;
- discard the packer half-word and all FIFO words not in flight;
- complete any in-flight transfer per REQ-011;
- then go to IDLE.
abort in IDLE or DONE SHALL have no effect.
REQ-019 busy SHALL be 1 in CAPTURE and DRAIN, and in an abort wind-down. done SHALL be 1 only in DONE.

Reset
REQ-020 lock=0 SHALL asynchronously force state IDLE and empty the FIFO and packer. It SHALL also force in_ready=0, avm_write=0, avm_chipselect=0, avm_address=BASE_ADDR, avm_writedata=0, avm_byteenable=2'b11, busy=0, done=0, overflow=0 and words_written=0.
REQ-021 Reset SHALL take effect even mid-transfer; after lock rises, the block SHALL remain in IDLE until start.

Verification
REQ-022 Reset: assert lock=0 mid-write with waitrequest=1 -> avm_write=0 immediately without a clock edge, and all REQ-020 values hold.
REQ-023 Basic: LEN_WORDS=4, start, bytes 0x11..0x88 back-to-back, waitrequest=0 -> writes addr 0,1,2,3 with data 0x2211, 0x4433, 0x6655, 0x8877; then done=1, words_written=4, overflow=0.
REQ-024 Stall: waitrequest=1 for 5 cycles during word 2 -> address and data stable for 6 cycles, exactly one transfer counted, words_written ends at 4.
REQ-025 Overflow: waitrequest=1 for 40 cycles, in_valid always 1, LEN_WORDS=64 -> in_ready=0 after 32 bytes accepted, overflow=1, and no FIFO word is corrupted after release.
REQ-026 Wrap: BASE_ADDR=25'h1FFFFFE, LEN_WORDS=4 -> addresses 1FFFFFE, 1FFFFFF, 0, 1.
REQ-027 Abort: abort after 5 bytes with waitrequest=1 on word 1 -> word 1 completes once waitrequest falls, word 2 and the half-word are never written, state returns to IDLE, and done=0.
